// File: rtl/rib_sram_slave_if.sv
// RIB slave-side bus: request/grant plus response/ready handshake between a master and an SRAM responder.
interface rib_sram_slave_if;
  logic [31:0] addr;
  logic        wrcs;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        req;
  logic        gnt;
  logic        rsp;
  logic [31:0] rdata;
  logic        rdy;

  modport master (
    output addr, wrcs, mask, wdata, req, rdy,
    input  gnt, rsp, rdata
  );

  modport slave (
    input  addr, wrcs, mask, wdata, req, rdy,
    output gnt, rsp, rdata
  );
endinterface

// File: rtl/rib_sram_slave.sv
// Word-organised SRAM responder on the RIB bus: byte-masked writes, word reads,
// programmable wait states and a single-entry response register held under back-pressure.
module rib_sram_slave #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  rib_sram_slave_if.slave  ribs
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                rsp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   word_c;
  logic                gnt_c;
  logic                accept_c;
  logic [DATA_W-1:0]   resp_data_c;
  logic                unused_addr_c;

  assign word_c        = ribs.addr[ADDR_W+1:2];
  assign unused_addr_c = ^{ribs.addr[31:ADDR_W+2], ribs.addr[1:0]};

  // Grant depends only on state and rdy, never on req.
  always_comb begin
    gnt_c = 1'b0;
    case (state)
      ST_IDLE: gnt_c = 1'b1;
      ST_RESP: gnt_c = (WAIT == 0) ? ribs.rdy : 1'b0;
      default: gnt_c = 1'b0;
    endcase
  end

  assign accept_c    = ribs.req & gnt_c;
  assign resp_data_c = ribs.wrcs ? '0 : mem[word_c];

  assign ribs.gnt   = gnt_c;
  assign ribs.rsp   = rsp_q;
  assign ribs.rdata = rdata_q;

  // Writes commit at their own accept edge so a following read sees them.
  always_ff @(posedge i_clk) begin
    if (accept_c && ribs.wrcs) begin
      for (int b = 0; b < 4; b++) begin
        if (ribs.mask[b]) mem[word_c][8*b +: 8] <= ribs.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            rdata_q <= resp_data_c;
            if (WAIT == 0) begin
              state <= ST_RESP;
              rsp_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
            rsp_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // Response register only changes once the current response is taken.
          if (ribs.rdy) begin
            if (accept_c) begin
              rdata_q <= resp_data_c;
            end else begin
              state <= ST_IDLE;
              rsp_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          rsp_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rib_sram_slave.sv
// Scoreboard bench for rib_sram_slave: a zero-wait small-memory instance and a 3-wait-state instance
// share one stimulus driver, selected by sel.
module tb_rib_sram_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel, req, wrcs, rdy;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;

  rib_sram_slave_if ifa ();
  rib_sram_slave_if ifb ();

  rib_sram_slave #(.ADDR_W(4), .WAIT(0)) u_a (.i_clk(clk), .i_rstn(rst_n), .ribs(ifa.slave));
  rib_sram_slave #(.ADDR_W(12), .WAIT(3)) u_b (.i_clk(clk), .i_rstn(rst_n), .ribs(ifb.slave));

  assign ifa.addr = addr;  assign ifb.addr = addr;
  assign ifa.wrcs = wrcs;  assign ifb.wrcs = wrcs;
  assign ifa.mask = mask;  assign ifb.mask = mask;
  assign ifa.wdata = wdata; assign ifb.wdata = wdata;
  assign ifa.rdy = rdy;    assign ifb.rdy = rdy;
  assign ifa.req = req & ~sel;
  assign ifb.req = req & sel;

  logic        gnt_m, rsp_m;
  logic [31:0] rdata_m;
  assign gnt_m   = sel ? ifb.gnt   : ifa.gnt;
  assign rsp_m   = sel ? ifb.rsp   : ifa.rsp;
  assign rdata_m = sel ? ifb.rdata : ifa.rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int xfer_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed response transfer is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_m === 1'b1 && rdy === 1'b1) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h expected no response (t=%0t)", rdata_m, $time);
      end else begin
        chk("rsp_rdata", rdata_m, exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge with req still high.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] e);
    int n;
    req = 1'b1; wrcs = w; addr = a; mask = m; wdata = d;
    exp_q.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt_m === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout: got no gnt expected gnt within 50 cycles (addr %h)", a);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req = 1'b0; wrcs = 1'b0; addr = '0; wdata = '0; mask = '0; rdy = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_a_rsp", 32'(ifa.rsp), 32'd0);
    chk("rst_a_rdata", ifa.rdata, 32'd0);
    chk("rst_a_gnt", 32'(ifa.gnt), 32'd1);
    chk("rst_b_rsp", 32'(ifb.rsp), 32'd0);
    chk("rst_b_gnt", 32'(ifb.gnt), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_a_gnt", 32'(ifa.gnt), 32'd1);
    chk("post_rst_b_rdata", ifb.rdata, 32'd0);

    // Masked writes, a zero-mask write, then read-back one cycle after accept.
    issue(1'b1, 32'h10, 4'b1111, 32'hAABBCCDD, 32'h0);
    issue(1'b1, 32'h10, 4'b0101, 32'h11223344, 32'h0);
    issue(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0);
    issue(1'b0, 32'h10, 4'b1111, 32'h0, 32'hAA22CC44);
    req = 1'b0;
    @(negedge clk);
    chk("rd_latency_rsp", 32'(rsp_m), 32'd1);
    chk("rd_latency_data", rdata_m, 32'hAA22CC44);
    idle(2);

    // Back-pressure: response held stable with gnt low while rdy is low.
    issue(1'b1, 32'h20, 4'b1111, 32'h12345678, 32'h0);
    idle(2);
    rdy = 1'b0;
    issue(1'b0, 32'h20, 4'b1111, 32'h0, 32'h12345678);
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp", 32'(rsp_m), 32'd1);
      chk("bp_rdata", rdata_m, 32'h12345678);
      chk("bp_gnt", 32'(gnt_m), 32'd0);
    end
    @(posedge clk); #1 rdy = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_gnt", 32'(gnt_m), 32'd1);
    chk("bp_idle_rsp", 32'(rsp_m), 32'd0);
    idle(1);

    // Back-to-back writes then reads, one transfer per cycle.
    for (int k = 0; k < 8; k++) issue(1'b1, 32'(4 * k), 4'b1111, 32'(k), 32'h0);
    for (int k = 0; k < 8; k++) issue(1'b0, 32'(4 * k), 4'b1111, 32'h0, 32'(k));
    idle(3);
    chk("b2b_span", 32'(xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[xfer_cyc.size() - 8]), 32'd7);

    // Aliasing on the 16-word instance.
    issue(1'b1, 32'h4, 4'b1111, 32'hDEADBEEF, 32'h0);
    issue(1'b0, 32'h44, 4'b1111, 32'h0, 32'hDEADBEEF);
    issue(1'b0, 32'h7, 4'b1111, 32'h0, 32'hDEADBEEF);
    idle(3);

    // Wait states on the WAIT=3 instance.
    sel = 1'b1;
    issue(1'b1, 32'h30, 4'b1111, 32'hCAFEF00D, 32'h0);
    idle(8);
    issue(1'b0, 32'h30, 4'b1111, 32'h0, 32'hCAFEF00D);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ws_rsp", 32'(rsp_m), (i == 3) ? 32'd1 : 32'd0);
      chk("ws_gnt", 32'(gnt_m), 32'd0);
    end
    @(negedge clk);
    chk("ws_done_gnt", 32'(gnt_m), 32'd1);
    chk("ws_done_rsp", 32'(rsp_m), 32'd0);
    idle(1);

    // Reset during the wait phase of a read.
    issue(1'b1, 32'h40, 4'b1111, 32'h0BADF00D, 32'h0);
    idle(8);
    issue(1'b0, 32'h40, 4'b1111, 32'h0, 32'h0BADF00D);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("midrst_rsp", 32'(rsp_m), 32'd0);
    chk("midrst_rdata", rdata_m, 32'd0);
    chk("midrst_gnt", 32'(gnt_m), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_rsp", 32'(rsp_m), 32'd0);
    end
    @(posedge clk); #1;
    issue(1'b0, 32'h40, 4'b1111, 32'h0, 32'h0BADF00D);
    idle(8);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
